mem_dbus_stage: RTL and testbench

//  MEM stage of the MiniMIPS32 pipeline. Sits between exmem_reg and memwb_reg.

---
 rtl/mem_dbus_stage_pkg.sv | 38 +++
 rtl/mem_dbus_stage_if.sv | 13 +
 rtl/mem_dbus_stage_lane_gen.sv | 39 +++
 rtl/mem_dbus_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_dbus_stage.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dbus_stage_pkg.sv
// Shared op codes, FSM encodings and bus request record for the MEM stage.
package mem_dbus_stage_pkg;

  localparam int ALUOP_W = 8;
  localparam int STALL_W = 5;
  localparam logic NOSTOP = 1'b0;

  // Memory op codes as decoded by ID/EX
  localparam logic [ALUOP_W-1:0] MINIMIPS32_LB   = 8'h90;
  localparam logic [ALUOP_W-1:0] MINIMIPS32_LBU  = 8'h91;
  localparam logic [ALUOP_W-1:0] MINIMIPS32_LH   = 8'h92;
  localparam logic [ALUOP_W-1:0] MINIMIPS32_LHU  = 8'h93;
  localparam logic [ALUOP_W-1:0] MINIMIPS32_LW   = 8'h94;
  localparam logic [ALUOP_W-1:0] MINIMIPS32_SB   = 8'h98;
  localparam logic [ALUOP_W-1:0] MINIMIPS32_SH   = 8'h99;
  localparam logic [ALUOP_W-1:0] MINIMIPS32_SW   = 8'h9A;
  localparam logic [ALUOP_W-1:0] MINIMIPS32_ADDU = 8'h19;
  localparam logic [ALUOP_W-1:0] MINIMIPS32_NOP  = 8'h00;

  // Bus FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Request fields held stable for the life of one bus transaction
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbus_req_t;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_dbus_stage_if.sv
// req/ack data bus between the MEM stage (master) and memory (slave).
interface mem_dbus_stage_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input ack, rdata);
  modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_dbus_stage_lane_gen.sv
// Decodes a memory op into byte enables, lane-replicated store data and load flags.
module mem_lane_gen
  import mem_dbus_stage_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [1:0]         addr_lo,
  input  logic [31:0]        din,
  output logic [3:0]         be,
  output logic [31:0]        wdata,
  output logic               is_load,
  output logic               is_store,
  output logic               sext
);

  // Little-endian lane selection; alignment was already checked in EX
  always_comb begin
    be       = 4'b0000;
    wdata    = din;
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    case (aluop)
      MINIMIPS32_LB, MINIMIPS32_LBU, MINIMIPS32_SB: be = 4'b0001 << addr_lo;
      MINIMIPS32_LH, MINIMIPS32_LHU, MINIMIPS32_SH: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      MINIMIPS32_LW, MINIMIPS32_SW:                 be = 4'b1111;
      default:                                      be = 4'b0000;
    endcase
    case (aluop)
      MINIMIPS32_SB: wdata = {4{din[7:0]}};
      MINIMIPS32_SH: wdata = {2{din[15:0]}};
      default:       wdata = din;
    endcase
    is_load  = aluop inside {MINIMIPS32_LB, MINIMIPS32_LBU, MINIMIPS32_LH,
                             MINIMIPS32_LHU, MINIMIPS32_LW};
    is_store = aluop inside {MINIMIPS32_SB, MINIMIPS32_SH, MINIMIPS32_SW};
    sext     = aluop inside {MINIMIPS32_LB, MINIMIPS32_LH};
  end

endmodule

// File: rtl/mem_dbus_stage.sv
// MEM stage: runs loads/stores on a variable-latency req/ack bus and stalls
// the pipeline until the access completes. Non-memory ops pass straight through.
module mem_dbus_stage
  import mem_dbus_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                cpu_clk_50M,
  input  logic                cpu_rst_n,
  input  logic [ALUOP_W-1:0]  exe_aluop,
  input  logic [4:0]          exe_wa,
  input  logic                exe_wreg,
  input  logic [31:0]         exe_wd,
  input  logic [31:0]         exe_din,
  input  logic                exe_whilo,
  input  logic [63:0]         exe_hilo,
  input  logic                exe_cp0_we,
  input  logic [4:0]          exe_cp0_waddr,
  input  logic [31:0]         exe_cp0_wdata,
  input  logic [31:0]         exe_pc,
  input  logic                flush,
  input  logic [STALL_W-1:0]  stall,
  output logic                stallreq_mem,
  mem_dbus_stage_if.master    dbus,
  output logic                bus_err,
  output logic [4:0]          mem_wa,
  output logic                mem_wreg,
  output logic [31:0]         mem_dreg,
  output logic                mem_mreg,
  output logic [3:0]          mem_dre,
  output logic                mem_whilo,
  output logic [63:0]         mem_hilo,
  output logic                mem_extendtype,
  output logic                mem_cp0_we,
  output logic [4:0]          mem_cp0_waddr,
  output logic [31:0]         mem_cp0_wdata,
  output logic [31:0]         de_pc_i
);

  logic [3:0]  gen_be;
  logic [31:0] gen_wdata;
  logic        is_load, is_store, sext, is_mem;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  dbus_req_t        breq_q, breq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             stall_c, tmo, bus_done;

  // Only the memwb hold bit matters here
  logic unused_stall;
  assign unused_stall = ^stall[STALL_W-2:0];

  mem_lane_gen u_lane (
    .aluop    (exe_aluop),
    .addr_lo  (exe_wd[1:0]),
    .din      (exe_din),
    .be       (gen_be),
    .wdata    (gen_wdata),
    .is_load  (is_load),
    .is_store (is_store),
    .sext     (sext)
  );

  assign is_mem   = is_load | is_store;
  assign tmo      = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign bus_done = dbus.ack | tmo;

  // Bus FSM: issue, wait for ack/timeout, drain flushed accesses, hold result
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    breq_d  = breq_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mem && !flush) begin
          stall_c = 1'b1;
          req_d   = 1'b1;
          cnt_d   = '0;
          breq_d  = '{we: is_store, be: gen_be, addr: word_addr(exe_wd), wdata: gen_wdata};
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A flushed instruction must not hold the pipeline, but the bus
        // access already in flight still has to finish.
        stall_c = !flush;
        cnt_d   = cnt_q + CNT_W'(1);
        if (bus_done) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          err_d   = !dbus.ack;
          rdata_d = dbus.ack ? dbus.rdata : 32'h0;
          state_d = flush ? ST_IDLE : ST_DONE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A younger mem op waits here until the abandoned access retires
        stall_c = is_mem && !flush;
        cnt_d   = cnt_q + CNT_W'(1);
        if (bus_done) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          err_d   = !dbus.ack;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (flush || stall[4] == NOSTOP) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and bus request registers; reset abandons any outstanding request
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      breq_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      breq_q  <= breq_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign stallreq_mem = cpu_rst_n & stall_c;

  assign dbus.req   = req_q;
  assign dbus.we    = breq_q.we;
  assign dbus.be    = breq_q.be;
  assign dbus.addr  = breq_q.addr;
  assign dbus.wdata = breq_q.wdata;
  assign bus_err    = err_q;

  // Loads hand the raw word and lane mask to WB for extraction/extension
  assign mem_mreg       = is_load;
  assign mem_dreg       = is_load ? rdata_q : exe_wd;
  assign mem_dre        = is_load ? breq_q.be : 4'b0000;
  assign mem_extendtype = sext;

  assign mem_wa        = exe_wa;
  assign mem_wreg      = exe_wreg;
  assign mem_whilo     = exe_whilo;
  assign mem_hilo      = exe_hilo;
  assign mem_cp0_we    = exe_cp0_we;
  assign mem_cp0_waddr = exe_cp0_waddr;
  assign mem_cp0_wdata = exe_cp0_wdata;
  assign de_pc_i       = exe_pc;

endmodule

// File: tb/tb_mem_dbus_stage.sv
// Scoreboard bench for mem_dbus_stage: a bus slave checks requests against
// queued expectations, a retire monitor checks the memwb bundle.
module tb_mem_dbus_stage;
  import mem_dbus_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  exe_aluop = MINIMIPS32_NOP;
  logic [4:0]  exe_wa = '0;
  logic        exe_wreg = 1'b0;
  logic [31:0] exe_wd = '0, exe_din = '0;
  logic        exe_whilo = 1'b0;
  logic [63:0] exe_hilo = '0;
  logic        exe_cp0_we = 1'b0;
  logic [4:0]  exe_cp0_waddr = '0;
  logic [31:0] exe_cp0_wdata = '0, exe_pc = '0;
  logic        flush = 1'b0;
  logic [4:0]  stall = '0;
  logic        stallreq_mem, bus_err;
  logic [4:0]  mem_wa, mem_cp0_waddr;
  logic        mem_wreg, mem_mreg, mem_whilo, mem_extendtype, mem_cp0_we;
  logic [31:0] mem_dreg, mem_cp0_wdata, de_pc_i;
  logic [3:0]  mem_dre;
  logic [63:0] mem_hilo;

  mem_dbus_stage_if dbus();

  mem_dbus_stage #(.ACK_TIMEOUT(16), .CNT_W(5)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .exe_aluop(exe_aluop), .exe_wa(exe_wa),
    .exe_wreg(exe_wreg), .exe_wd(exe_wd), .exe_din(exe_din), .exe_whilo(exe_whilo),
    .exe_hilo(exe_hilo), .exe_cp0_we(exe_cp0_we), .exe_cp0_waddr(exe_cp0_waddr),
    .exe_cp0_wdata(exe_cp0_wdata), .exe_pc(exe_pc), .flush(flush), .stall(stall),
    .stallreq_mem(stallreq_mem), .dbus(dbus.master), .bus_err(bus_err),
    .mem_wa(mem_wa), .mem_wreg(mem_wreg), .mem_dreg(mem_dreg), .mem_mreg(mem_mreg),
    .mem_dre(mem_dre), .mem_whilo(mem_whilo), .mem_hilo(mem_hilo),
    .mem_extendtype(mem_extendtype), .mem_cp0_we(mem_cp0_we),
    .mem_cp0_waddr(mem_cp0_waddr), .mem_cp0_wdata(mem_cp0_wdata), .de_pc_i(de_pc_i)
  );

  typedef struct {
    logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; logic chk_wd;
    int delay; logic [31:0] rdata; int len;
  } bus_exp_t;

  typedef struct {
    logic [31:0] dreg; logic mreg; logic [3:0] dre; logic ext; logic err;
    int stalls; int seq;
  } ret_exp_t;

  bus_exp_t bq[$];
  ret_exp_t rq[$];
  int n_chk = 0, n_err = 0;
  logic tb_vld = 1'b0;
  int seq = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: got unexpected/missing event want none", nm);
  endtask

  // Pass-through fields are a function of the instruction sequence number
  task automatic drive_pass(input int s);
    exe_wa        = 5'(s);
    exe_wreg      = ~s[0];
    exe_whilo     = s[1];
    exe_hilo      = {32'(s), ~32'(s)};
    exe_cp0_we    = s[0];
    exe_cp0_waddr = 5'(s + 1);
    exe_cp0_wdata = 32'h1000 + 32'(s);
    exe_pc        = 32'hBFC0_0000 + 32'(s * 4);
  endtask

  // Bus slave + request checker: pops one expectation per request
  bus_exp_t cur;
  int blen = 0;
  logic in_txn = 1'b0;
  initial begin
    dbus.ack = 1'b0;
    dbus.rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dbus.req && rst_n) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          blen = 0;
          if (bq.size() == 0) begin
            fail("bus_unexpected");
            cur = '{addr: 0, be: 0, we: 0, wdata: 0, chk_wd: 0, delay: 0, rdata: 0, len: 0};
          end else begin
            cur = bq.pop_front();
            chk("bus_addr", dbus.addr, cur.addr);
            chk("bus_be", dbus.be, cur.be);
            chk("bus_we", dbus.we, cur.we);
            if (cur.chk_wd) chk("bus_wdata", dbus.wdata, cur.wdata);
          end
        end
        blen++;
        dbus.ack   = (cur.delay != 0) && (blen == cur.delay);
        dbus.rdata = dbus.ack ? cur.rdata : 32'h0;
      end else begin
        if (in_txn) begin
          in_txn = 1'b0;
          chk("bus_req_len", blen, cur.len);
        end
        dbus.ack = 1'b0;
        dbus.rdata = '0;
      end
    end
  end

  // Retire monitor: an instruction retires in the first cycle without stall
  int st_cnt = 0;
  ret_exp_t re;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tb_vld) begin
        if (stallreq_mem) st_cnt++;
        else begin
          if (rq.size() == 0) fail("ret_unexpected");
          else begin
            re = rq.pop_front();
            chk("ret_dreg", mem_dreg, re.dreg);
            chk("ret_mreg", mem_mreg, re.mreg);
            chk("ret_dre", mem_dre, re.dre);
            chk("ret_ext", mem_extendtype, re.ext);
            chk("ret_bus_err", bus_err, re.err);
            chk("ret_stalls", st_cnt, re.stalls);
            chk("ret_pc", de_pc_i, 32'hBFC0_0000 + 32'(re.seq * 4));
            chk("ret_hilo", mem_hilo, {32'(re.seq), ~32'(re.seq)});
            chk("ret_cp0_wdata", mem_cp0_wdata, 32'h1000 + 32'(re.seq));
            chk("ret_misc", {mem_wa, mem_wreg, mem_whilo, mem_cp0_we, mem_cp0_waddr},
                {5'(re.seq), ~re.seq[0], re.seq[1], re.seq[0], 5'(re.seq + 1)});
          end
          st_cnt = 0;
        end
      end
    end
  end

  // Issue one instruction (inputs change 1 time unit after posedge) and wait for retire
  task automatic run_op(input logic [7:0] op, input logic [31:0] wd, input logic [31:0] din,
                        input int dly, input logic [31:0] rd, input logic [3:0] b_be,
                        input logic [31:0] b_wdata, input int b_len, input logic [31:0] e_dreg,
                        input logic [3:0] e_dre, input logic e_ext, input logic e_err,
                        input int e_stl, input int hold);
    bus_exp_t b;
    ret_exp_t r;
    logic ld, sto, done;
    ld  = op inside {MINIMIPS32_LB, MINIMIPS32_LBU, MINIMIPS32_LH, MINIMIPS32_LHU, MINIMIPS32_LW};
    sto = op inside {MINIMIPS32_SB, MINIMIPS32_SH, MINIMIPS32_SW};
    seq++;
    if (ld || sto) begin
      b = '{addr: {wd[31:2], 2'b00}, be: b_be, we: sto, wdata: b_wdata, chk_wd: sto,
            delay: dly, rdata: rd, len: b_len};
      bq.push_back(b);
    end
    r = '{dreg: e_dreg, mreg: ld, dre: e_dre, ext: e_ext, err: e_err, stalls: e_stl, seq: seq};
    rq.push_back(r);
    exe_aluop = op; exe_wd = wd; exe_din = din;
    drive_pass(seq);
    stall = (hold > 0) ? 5'b10000 : 5'b00000;
    tb_vld = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stallreq_mem) begin done = 1'b1; break; end
    end
    if (!done) fail("retire_timeout");
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      tb_vld = 1'b0;
      @(negedge clk);
      chk("hold_req", dbus.req, 1'b0);
      chk("hold_stallreq", stallreq_mem, 1'b0);
      chk("hold_dreg", mem_dreg, e_dreg);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      stall = '0;
      tb_vld = 1'b0;
    end
    @(posedge clk); #1;
    tb_vld = 1'b0;
    exe_aluop = MINIMIPS32_NOP;
    stall = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got sim time limit want summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, with a load presented so stall suppression is visible
    exe_aluop = MINIMIPS32_LW; exe_wd = 32'h100;
    #12;
    chk("rst_stallreq", stallreq_mem, 1'b0);
    chk("rst_bus", {dbus.req, dbus.we, dbus.be, dbus.addr, dbus.wdata}, '0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_dreg", mem_dreg, 32'h0);
    chk("rst_dre", mem_dre, 4'h0);
    exe_aluop = MINIMIPS32_NOP;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // op  addr  din  delay rdata  bus_be bus_wdata len  dreg  dre ext err stalls hold
    run_op(MINIMIPS32_LW,  32'h100, 32'h0,        3, 32'hDEADBEEF, 4'hF, 32'h0,        3, 32'hDEADBEEF, 4'hF, 0, 0, 4, 0);
    run_op(MINIMIPS32_SB,  32'h103, 32'h12345678, 1, 32'h0,        4'h8, 32'h78787878, 1, 32'h103,      4'h0, 0, 0, 2, 0);
    run_op(MINIMIPS32_LH,  32'h102, 32'h0,        2, 32'h80014321, 4'hC, 32'h0,        2, 32'h80014321, 4'hC, 1, 0, 3, 0);
    run_op(MINIMIPS32_LHU, 32'h102, 32'h0,        2, 32'h80014321, 4'hC, 32'h0,        2, 32'h80014321, 4'hC, 0, 0, 3, 0);
    run_op(MINIMIPS32_LB,  32'h101, 32'h0,        1, 32'h00A50000, 4'h2, 32'h0,        1, 32'h00A50000, 4'h2, 1, 0, 2, 0);
    run_op(MINIMIPS32_LBU, 32'h102, 32'h0,        1, 32'h12345678, 4'h4, 32'h0,        1, 32'h12345678, 4'h4, 0, 0, 2, 0);
    run_op(MINIMIPS32_SH,  32'h102, 32'hCAFEBABE, 2, 32'h0,        4'hC, 32'hBABEBABE, 2, 32'h102,      4'h0, 0, 0, 3, 0);
    run_op(MINIMIPS32_SH,  32'h100, 32'h00001234, 1, 32'h0,        4'h3, 32'h12341234, 1, 32'h100,      4'h0, 0, 0, 2, 0);
    run_op(MINIMIPS32_SW,  32'h204, 32'h11223344, 1, 32'h0,        4'hF, 32'h11223344, 1, 32'h204,      4'h0, 0, 0, 2, 0);
    // Result held in DONE under a memwb stall, no reissue
    run_op(MINIMIPS32_LW,  32'h700, 32'h0,        1, 32'h13572468, 4'hF, 32'h0,        1, 32'h13572468, 4'hF, 0, 0, 2, 3);
    // Back-to-back load / ALU op / store
    run_op(MINIMIPS32_LW,  32'h104, 32'h0,        1, 32'hA5A5A5A5, 4'hF, 32'h0,        1, 32'hA5A5A5A5, 4'hF, 0, 0, 2, 0);
    run_op(MINIMIPS32_ADDU,32'h5555AAAA, 32'h0,   0, 32'h0,        4'h0, 32'h0,        0, 32'h5555AAAA, 4'h0, 0, 0, 0, 0);
    run_op(MINIMIPS32_SW,  32'h108, 32'h0F0F0F0F, 1, 32'h0,        4'hF, 32'h0F0F0F0F, 1, 32'h108,      4'h0, 0, 0, 2, 0);
    // No ack: 16 request cycles, then error pulse and zeroed data
    run_op(MINIMIPS32_LW,  32'h300, 32'h0,        0, 32'h0,        4'hF, 32'h0,       16, 32'h0,        4'hF, 0, 1, 17, 0);
    @(negedge clk);
    chk("tmo_err_single", bus_err, 1'b0);
    chk("tmo_idle_req", dbus.req, 1'b0);
    @(posedge clk); #1;

    // Flush one cycle after issue; ack arrives on the 6th request cycle
    bq.push_back('{addr: 32'h400, be: 4'hF, we: 1'b0, wdata: 32'h0, chk_wd: 1'b0,
                   delay: 6, rdata: 32'h99999999, len: 6});
    exe_aluop = MINIMIPS32_LW; exe_wd = 32'h400;
    @(negedge clk);
    chk("fl_issue_stall", stallreq_mem, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_flush_stall", stallreq_mem, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; exe_aluop = MINIMIPS32_NOP;
    @(negedge clk);
    chk("fl_drain_stall", stallreq_mem, 1'b0);
    chk("fl_drain_req", dbus.req, 1'b1);
    chk("fl_drain_mreg", mem_mreg, 1'b0);
    @(posedge clk); #1;
    run_op(MINIMIPS32_LW,  32'h500, 32'h0,        2, 32'h0BADF00D, 4'hF, 32'h0,        2, 32'h0BADF00D, 4'hF, 0, 0, 7, 0);

    // Async reset in the middle of a wait
    bq.push_back('{addr: 32'h600, be: 4'hF, we: 1'b0, wdata: 32'h0, chk_wd: 1'b0,
                   delay: 0, rdata: 32'h0, len: 3});
    exe_aluop = MINIMIPS32_LW; exe_wd = 32'h600;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", dbus.req, 1'b0);
    chk("mid_rst_bus", {dbus.we, dbus.be, dbus.addr, dbus.wdata}, '0);
    chk("mid_rst_stallreq", stallreq_mem, 1'b0);
    chk("mid_rst_dreg", mem_dreg, 32'h0);
    exe_aluop = MINIMIPS32_NOP;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(MINIMIPS32_LW,  32'h800, 32'h0,        1, 32'h00000042, 4'hF, 32'h0,        1, 32'h00000042, 4'hF, 0, 0, 2, 0);

    repeat (4) @(posedge clk);
    chk("bus_queue_empty", bq.size(), 0);
    chk("ret_queue_empty", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
